// File: rtl/pee_python_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pee_python_responder_if : PEE python handshake plus tagged host channel
// Rev 1.0
// ---------------------------------------------------------------------------
interface pee_python_responder_if #(
   parameter int TAG_W = 4
);
   logic              python_req;
   logic [31:0]       python_code_addr;
   logic              python_ack;
   logic [31:0]       python_result;
   logic              python_error;
   logic              host_req_valid;
   logic [31:0]       host_req_addr;
   logic [TAG_W-1:0]  host_req_tag;
   logic              host_req_ready;
   logic              host_rsp_valid;
   logic [TAG_W-1:0]  host_rsp_tag;
   logic [31:0]       host_rsp_data;
   logic              host_rsp_error;
   logic              host_rsp_ready;
   logic [15:0]       stale_count;
   logic [15:0]       timeout_count;

   // master drives requests and host responses; slave is the responder
   modport master (
      output python_req, python_code_addr, host_req_ready,
             host_rsp_valid, host_rsp_tag, host_rsp_data, host_rsp_error,
      input  python_ack, python_result, python_error, host_req_valid,
             host_req_addr, host_req_tag, host_rsp_ready, stale_count, timeout_count
   );

   modport slave (
      input  python_req, python_code_addr, host_req_ready,
             host_rsp_valid, host_rsp_tag, host_rsp_data, host_rsp_error,
      output python_ack, python_result, python_error, host_req_valid,
             host_req_addr, host_req_tag, host_rsp_ready, stale_count, timeout_count
   );
endinterface
`default_nettype wire

// File: rtl/pee_python_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pee_python_responder : forwards PEE python requests to a tagged host agent,
//                        matches responses, enforces a timeout.
// Rev 1.0
// ---------------------------------------------------------------------------
module pee_python_responder #(
   parameter int          TAG_W          = 4,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFF0,
   parameter logic [31:0] ERR_TIMEOUT    = 32'h4001
) (
   input  logic                  clk,
   input  logic                  rst,
   pee_python_responder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      AWAIT = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [31:0]       addr_q, addr_d;
   logic [15:0]       timer_q, timer_d;
   logic [31:0]       result_q, result_d;
   logic              error_q, error_d;
   logic [15:0]       stale_q, stale_d;
   logic [15:0]       tmo_q, tmo_d;

   logic w_match;
   logic w_expire;
   logic w_running;

   assign w_running = (state_q == ISSUE) || (state_q == AWAIT);
   // expiry is flagged on the cycle whose decrement lands on zero
   assign w_expire  = (timer_q <= 16'd1);
   assign w_match   = (state_q == AWAIT) && bus.host_rsp_valid && (bus.host_rsp_tag == tag_q);

   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      addr_d   = addr_q;
      timer_d  = timer_q;
      result_d = result_q;
      error_d  = error_q;
      stale_d  = stale_q;
      tmo_d    = tmo_q;

      if (w_running && (timer_q != 16'd0)) begin
         timer_d = timer_q - 16'd1;
      end

      if (bus.python_req) begin
         addr_d  = bus.python_code_addr;
         tag_d   = tag_q + TAG_W'(1);
         timer_d = TIMEOUT_CYCLES;
         state_d = ISSUE;
      end else begin
         case (state_q)
            ISSUE: begin
               if (w_expire) begin
                  result_d = ERR_TIMEOUT;
                  error_d  = 1'b1;
                  tmo_d    = (tmo_q != 16'hFFFF) ? tmo_q + 16'd1 : tmo_q;
                  state_d  = ACK;
               end else if (bus.host_req_ready) begin
                  state_d = AWAIT;
               end
            end
            AWAIT: begin
               if (w_match) begin
                  result_d = bus.host_rsp_data;
                  error_d  = bus.host_rsp_error;
                  state_d  = ACK;
               end else if (w_expire) begin
                  result_d = ERR_TIMEOUT;
                  error_d  = 1'b1;
                  tmo_d    = (tmo_q != 16'hFFFF) ? tmo_q + 16'd1 : tmo_q;
                  state_d  = ACK;
               end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // a new request pre-empts even a matching response
      if (bus.host_rsp_valid && !(w_match && !bus.python_req)) begin
         stale_d = (stale_q != 16'hFFFF) ? stale_q + 16'd1 : stale_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tag_q    <= '0;
         addr_q   <= '0;
         timer_q  <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
         stale_q  <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         addr_q   <= addr_d;
         timer_q  <= timer_d;
         result_q <= result_d;
         error_q  <= error_d;
         stale_q  <= stale_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.python_ack     = (state_q == ACK);
   assign bus.python_result  = result_q;
   assign bus.python_error   = error_q;
   assign bus.host_req_valid = (state_q == ISSUE);
   assign bus.host_req_addr  = addr_q;
   assign bus.host_req_tag   = tag_q;
   assign bus.host_rsp_ready = 1'b1;
   assign bus.stale_count    = stale_q;
   assign bus.timeout_count  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_pee_python_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pee_python_responder : directed vectors for pee_python_responder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pee_python_responder;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   n_wait;

   pee_python_responder_if #(.TAG_W(4)) bus ();

   pee_python_responder #(
      .TAG_W          (4),
      .TIMEOUT_CYCLES (16'd8),
      .ERR_TIMEOUT    (32'h4001)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr);
      bus.python_req       = 1'b1;
      bus.python_code_addr = addr;
      tick();
      bus.python_req       = 1'b0;
   endtask

   task automatic accept();
      bus.host_req_ready = 1'b1;
      tick();
      bus.host_req_ready = 1'b0;
   endtask

   task automatic send_rsp(input logic [3:0] tag, input logic [31:0] data, input logic err);
      bus.host_rsp_valid = 1'b1;
      bus.host_rsp_tag   = tag;
      bus.host_rsp_data  = data;
      bus.host_rsp_error = err;
      tick();
      bus.host_rsp_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_ack"},     32'(bus.python_ack),     32'd0);
      check_eq({pfx, "_result"},  bus.python_result,       32'd0);
      check_eq({pfx, "_error"},   32'(bus.python_error),   32'd0);
      check_eq({pfx, "_valid"},   32'(bus.host_req_valid), 32'd0);
      check_eq({pfx, "_addr"},    bus.host_req_addr,       32'd0);
      check_eq({pfx, "_tag"},     32'(bus.host_req_tag),   32'd0);
      check_eq({pfx, "_rsp_rdy"}, 32'(bus.host_rsp_ready), 32'd1);
      check_eq({pfx, "_stale"},   32'(bus.stale_count),    32'd0);
      check_eq({pfx, "_tmo"},     32'(bus.timeout_count),  32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst                  = 1'b1;
      bus.python_req       = 1'b0;
      bus.python_code_addr = '0;
      bus.host_req_ready   = 1'b0;
      bus.host_rsp_valid   = 1'b0;
      bus.host_rsp_tag     = '0;
      bus.host_rsp_data    = '0;
      bus.host_rsp_error   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_state("rst");

      // normal request / response
      issue(32'h0000_1234);
      check_eq("norm_valid", 32'(bus.host_req_valid), 32'd1);
      check_eq("norm_tag",   32'(bus.host_req_tag),   32'd1);
      check_eq("norm_addr",  bus.host_req_addr,       32'h0000_1234);
      accept();
      check_eq("norm_valid_drop", 32'(bus.host_req_valid), 32'd0);
      check_eq("norm_no_ack",     32'(bus.python_ack),     32'd0);
      send_rsp(4'd1, 32'hCAFE_F00D, 1'b0);
      check_eq("norm_ack",    32'(bus.python_ack),   32'd1);
      check_eq("norm_result", bus.python_result,     32'hCAFE_F00D);
      check_eq("norm_error",  32'(bus.python_error), 32'd0);
      tick();
      check_eq("norm_ack_once", 32'(bus.python_ack), 32'd0);

      // host-reported error
      issue(32'h0000_1234);
      check_eq("herr_tag", 32'(bus.host_req_tag), 32'd2);
      accept();
      send_rsp(4'd2, 32'h0, 1'b1);
      check_eq("herr_ack",    32'(bus.python_ack),   32'd1);
      check_eq("herr_result", bus.python_result,     32'd0);
      check_eq("herr_error",  32'(bus.python_error), 32'd1);
      tick();

      // timeout: ack lands 8 edges after the capture edge
      issue(32'h0000_2000);
      bus.host_req_ready = 1'b1;
      n_wait = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         bus.host_req_ready = 1'b0;
         n_wait = i;
         if (bus.python_ack) break;
      end
      check_eq("tmo_latency", 32'(n_wait),            32'd8);
      check_eq("tmo_result",  bus.python_result,      32'h4001);
      check_eq("tmo_error",   32'(bus.python_error),  32'd1);
      check_eq("tmo_count",   32'(bus.timeout_count), 32'd1);
      tick();
      check_eq("tmo_ack_once", 32'(bus.python_ack), 32'd0);

      // late response for the timed-out request
      send_rsp(4'd3, 32'hDEAD_BEEF, 1'b0);
      check_eq("stale_no_ack", 32'(bus.python_ack),  32'd0);
      check_eq("stale_count",  32'(bus.stale_count), 32'd1);
      check_eq("stale_result", bus.python_result,    32'h4001);
      check_eq("stale_error",  32'(bus.python_error), 32'd1);

      // abandon a pending request
      issue(32'h0000_1000);
      accept();
      issue(32'h0000_5678);
      check_eq("abn_tag",   32'(bus.host_req_tag),   32'd5);
      check_eq("abn_addr",  bus.host_req_addr,       32'h0000_5678);
      check_eq("abn_valid", 32'(bus.host_req_valid), 32'd1);
      check_eq("abn_no_ack", 32'(bus.python_ack),    32'd0);
      accept();
      send_rsp(4'd4, 32'h0000_0011, 1'b0);
      check_eq("abn_old_no_ack", 32'(bus.python_ack),  32'd0);
      check_eq("abn_old_stale",  32'(bus.stale_count), 32'd2);
      send_rsp(4'd5, 32'h0000_0077, 1'b0);
      check_eq("abn_ack",    32'(bus.python_ack),   32'd1);
      check_eq("abn_result", bus.python_result,     32'h0000_0077);
      check_eq("abn_error",  32'(bus.python_error), 32'd0);
      tick();
      check_eq("abn_ack_once", 32'(bus.python_ack),  32'd0);
      check_eq("abn_stale",    32'(bus.stale_count), 32'd2);

      // new request and matching response on the same edge
      issue(32'h0000_3000);
      accept();
      bus.python_req       = 1'b1;
      bus.python_code_addr = 32'h0000_4000;
      bus.host_rsp_valid   = 1'b1;
      bus.host_rsp_tag     = 4'd6;
      bus.host_rsp_data    = 32'h0000_0099;
      bus.host_rsp_error   = 1'b0;
      tick();
      bus.python_req     = 1'b0;
      bus.host_rsp_valid = 1'b0;
      check_eq("sim_no_ack", 32'(bus.python_ack),     32'd0);
      check_eq("sim_stale",  32'(bus.stale_count),    32'd3);
      check_eq("sim_tag",    32'(bus.host_req_tag),   32'd7);
      check_eq("sim_valid",  32'(bus.host_req_valid), 32'd1);
      check_eq("sim_result", bus.python_result,       32'h0000_0077);
      accept();
      send_rsp(4'd7, 32'h0000_00AB, 1'b0);
      check_eq("sim_ack",    32'(bus.python_ack), 32'd1);
      check_eq("sim_result2", bus.python_result,  32'h0000_00AB);
      tick();

      // reset while awaiting a response
      issue(32'h0000_6000);
      accept();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("mid_rst");
      send_rsp(4'd1, 32'h0000_0055, 1'b0);
      check_eq("late_no_ack", 32'(bus.python_ack),  32'd0);
      check_eq("late_stale",  32'(bus.stale_count), 32'd1);
      check_eq("late_result", bus.python_result,    32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
